// File: rtl/step_dir_decoder_pkg.sv
// Shared motion definitions: direction encoding and period-tracking FSM states.
package step_dir_decoder_pkg;

    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

    typedef enum logic [1:0] {
        PS_IDLE  = 2'd0,
        PS_ARMED = 2'd1,
        PS_TRACK = 2'd2,
        PS_STALL = 2'd3
    } per_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, with rising-edge and change detect
// against the previous synchronized value.
module sync_edge_det #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic change
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level  = sync_q[STAGES-1];
    assign rise   = level & ~prev_q;
    assign change = level ^ prev_q;

endmodule

// File: rtl/step_dir_decoder.sv
// Step/dir receiver: reconstructs signed position, measures step period, flags timing violations.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// PS_IDLE  | no step seen since reset/clear
// PS_ARMED | one step seen, interval to the next one is measurable
// PS_TRACK | period holds a real measurement (period_valid)
// PS_STALL | interval timer saturated while tracking (stalled)
module step_dir_decoder #(
    parameter int unsigned POS_W       = 64,
    parameter int unsigned PER_W       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MIN_PERIOD  = 4,
    parameter int unsigned DIR_SETUP   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             step_in,
    input  logic             dir_in,
    input  logic             load_pos,
    input  logic [POS_W-1:0] pos_val,
    input  logic             clear,
    input  logic             capture,
    input  logic             err_clr,
    output logic [POS_W-1:0] position,
    output logic [PER_W-1:0] period,
    output logic             period_valid,
    output logic             stalled,
    output logic             step_seen,
    output logic             dir_out,
    output logic [POS_W-1:0] cap_pos,
    output logic [PER_W-1:0] cap_period,
    output logic             overrun,
    output logic             setup_err
);

    import step_dir_decoder_pkg::*;

    localparam int unsigned      AGE_W       = $clog2(DIR_SETUP + 2);
    localparam logic [AGE_W-1:0] AGE_MAX     = AGE_W'(DIR_SETUP);
    localparam logic [PER_W-1:0] PER_MAX     = '1;
    localparam logic [PER_W-1:0] PER_MIN     = PER_W'(MIN_PERIOD);
    localparam logic [POS_W-1:0] POS_ONE     = POS_W'(1);
    localparam logic [POS_W-1:0] POS_NEG_ONE = '1;

    logic             step_evt;
    logic             dir_lvl;
    logic             dir_chg;
    logic             step_level_unused;
    logic             step_change_unused;
    logic             dir_rise_unused;

    logic             evt;
    per_state_t       state_q;
    per_state_t       state_d;
    logic             per_wr;
    logic [PER_W-1:0] timer_q;
    logic [PER_W-1:0] interval;
    logic [PER_W-1:0] per_d;
    logic [POS_W-1:0] pos_d;
    logic [POS_W-1:0] step_delta;
    logic [AGE_W-1:0] dir_age_q;
    logic [AGE_W-1:0] age_eff;
    logic [AGE_W-1:0] age_next;
    logic             ovr_set;
    logic             setup_set;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_step_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (step_in),
        .level    (step_level_unused),
        .rise     (step_evt),
        .change   (step_change_unused)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_dir_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (dir_in),
        .level    (dir_lvl),
        .rise     (dir_rise_unused),
        .change   (dir_chg)
    );

    // An event coinciding with clear is dropped everywhere, not just from position.
    assign evt      = step_evt & ~clear;
    assign interval = (timer_q == PER_MAX) ? PER_MAX : timer_q + PER_W'(1);

    // A dir change in the event cycle itself counts as age 0.
    assign age_eff  = dir_chg ? '0 : dir_age_q;
    assign age_next = (age_eff >= AGE_MAX) ? AGE_MAX : age_eff + AGE_W'(1);

    assign ovr_set   = evt && ((state_q == PS_ARMED) || (state_q == PS_TRACK)) && (interval < PER_MIN);
    assign setup_set = evt && (age_eff < AGE_MAX);

    assign period_valid = (state_q == PS_TRACK);
    assign stalled      = (state_q == PS_STALL);

    always_comb begin
        state_d = state_q;
        per_wr  = 1'b0;
        if (clear) begin
            state_d = PS_IDLE;
        end else begin
            case (state_q)
                PS_IDLE:  if (evt) state_d = PS_ARMED;
                PS_ARMED: begin
                    if (evt) begin
                        state_d = PS_TRACK;
                        per_wr  = 1'b1;
                    end
                end
                PS_TRACK: begin
                    if (evt) begin
                        per_wr = 1'b1;
                    end else if (timer_q == PER_MAX) begin
                        state_d = PS_STALL;
                    end
                end
                PS_STALL: if (evt) state_d = PS_ARMED;
                default:  state_d = PS_IDLE;
            endcase
        end
    end

    always_comb begin
        step_delta = POS_ONE;
        case (dir_lvl)
            DIR_POS: step_delta = POS_ONE;
            DIR_NEG: step_delta = POS_NEG_ONE;
            default: step_delta = POS_ONE;
        endcase

        pos_d = position;
        if (clear) begin
            pos_d = '0;
        end else if (load_pos) begin
            pos_d = pos_val;
        end else if (evt) begin
            pos_d = position + step_delta;
        end

        per_d = period;
        if (clear) begin
            per_d = '0;
        end else if (per_wr) begin
            per_d = interval;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= PS_IDLE;
            position   <= '0;
            period     <= '0;
            step_seen  <= 1'b0;
            dir_out    <= 1'b0;
            cap_pos    <= '0;
            cap_period <= '0;
            overrun    <= 1'b0;
            setup_err  <= 1'b0;
            timer_q    <= '0;
            dir_age_q  <= '0;
        end else begin
            state_q   <= state_d;
            position  <= pos_d;
            period    <= per_d;
            step_seen <= evt;
            dir_age_q <= age_next;
            if (evt) begin
                dir_out <= dir_lvl;
            end
            if (clear || evt) begin
                timer_q <= '0;
            end else if (timer_q != PER_MAX) begin
                timer_q <= timer_q + PER_W'(1);
            end
            // Capture sees this cycle's results, including a same-cycle step.
            if (capture) begin
                cap_pos    <= pos_d;
                cap_period <= per_d;
            end
            if (clear) begin
                overrun   <= 1'b0;
                setup_err <= 1'b0;
            end else begin
                overrun   <= (overrun & ~err_clr) | ovr_set;
                setup_err <= (setup_err & ~err_clr) | setup_set;
            end
        end
    end

endmodule

// File: tb/tb_step_dir_decoder.sv
// Self-checking bench for step_dir_decoder: position/dir/latency scoreboard plus direct flag checks.
module tb_step_dir_decoder;

    localparam int POS_W = 64;
    localparam int PER_W = 8;
    localparam int SYNC  = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             step_in;
    logic             dir_in;
    logic             load_pos;
    logic [POS_W-1:0] pos_val;
    logic             clear;
    logic             capture;
    logic             err_clr;
    logic [POS_W-1:0] position;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic             stalled;
    logic             step_seen;
    logic             dir_out;
    logic [POS_W-1:0] cap_pos;
    logic [PER_W-1:0] cap_period;
    logic             overrun;
    logic             setup_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int seen_cnt = 0;
    int seen_base;

    logic [63:0] exp_pos;
    logic [63:0] exp_q[$];
    logic        dir_q[$];
    int          cyc_q[$];

    step_dir_decoder #(
        .POS_W(POS_W), .PER_W(PER_W), .SYNC_STAGES(SYNC), .MIN_PERIOD(4), .DIR_SETUP(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .step_in(step_in), .dir_in(dir_in),
        .load_pos(load_pos), .pos_val(pos_val), .clear(clear), .capture(capture),
        .err_clr(err_clr), .position(position), .period(period),
        .period_valid(period_valid), .stalled(stalled), .step_seen(step_seen),
        .dir_out(dir_out), .cap_pos(cap_pos), .cap_period(cap_period),
        .overrun(overrun), .setup_err(setup_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // coinc bits assert err_clr / capture / clear during the cycle the step is decoded.
    task automatic step_gap(input logic d, input int gap, input logic [2:0] coinc);
        if (!coinc[2]) begin
            exp_pos = exp_pos + (d ? 64'd1 : 64'hFFFF_FFFF_FFFF_FFFF);
            exp_q.push_back(exp_pos);
            dir_q.push_back(d);
            cyc_q.push_back(cyc + SYNC + 1);
        end else begin
            exp_pos = '0;
        end
        step_in = 1'b1;
        tick(2);
        step_in = 1'b0;
        err_clr = coinc[0];
        capture = coinc[1];
        clear   = coinc[2];
        tick(1);
        err_clr = 1'b0;
        capture = 1'b0;
        clear   = 1'b0;
        tick(gap - 3);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        exp_pos = '0;
    endtask

    task automatic do_load(input logic [63:0] v);
        load_pos = 1'b1;
        pos_val  = v;
        tick(1);
        load_pos = 1'b0;
        exp_pos  = v;
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
    endtask

    initial begin
        logic [63:0] e_pos;
        logic        e_dir;
        int          e_cyc;
        forever begin
            @(negedge clk);
            if (reset_n && step_seen) begin
                seen_cnt++;
                chk("step_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e_pos = exp_q.pop_front();
                    e_dir = dir_q.pop_front();
                    e_cyc = cyc_q.pop_front();
                    chk("sb_position", position, e_pos);
                    chk("sb_dir_out", 64'(dir_out), 64'(e_dir));
                    chk("sb_latency", 64'(cyc), 64'(e_cyc));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; step_in = 1'b0; dir_in = 1'b1; load_pos = 1'b0; pos_val = '0;
        clear = 1'b0; capture = 1'b0; err_clr = 1'b0; exp_pos = '0;
        tick(3);
        chk("rst_position", position, 64'd0);
        chk("rst_period", 64'(period), 64'd0);
        chk("rst_valid", 64'(period_valid), 64'd0);
        chk("rst_stalled", 64'(stalled), 64'd0);
        chk("rst_step_seen", 64'(step_seen), 64'd0);
        chk("rst_flags", 64'({overrun, setup_err, dir_out}), 64'd0);
        reset_n = 1'b1;
        tick(6);

        // Five forward steps, 10 cycles apart
        seen_base = seen_cnt;
        repeat (5) step_gap(1'b1, 10, 3'b000);
        tick(6);
        chk("t1_position", position, 64'd5);
        chk("t1_period", 64'(period), 64'd10);
        chk("t1_valid", 64'(period_valid), 64'd1);
        chk("t1_seen_count", 64'(seen_cnt - seen_base), 64'd5);
        chk("t1_no_errors", 64'({overrun, setup_err}), 64'd0);

        // Loads and negative/positive stepping, including the signed wrap
        do_clear();
        do_load(64'hFFFF_FFFF_FFFF_FFFD);
        dir_in = 1'b0;
        tick(6);
        repeat (4) step_gap(1'b0, 10, 3'b000);
        tick(6);
        chk("t2_minus7", position, 64'hFFFF_FFFF_FFFF_FFF9);
        do_load(64'hFFFF_FFFF_FFFF_FFFF);
        dir_in = 1'b1;
        tick(6);
        step_gap(1'b1, 10, 3'b000);
        chk("t2_zero", position, 64'd0);
        do_load(64'h7FFF_FFFF_FFFF_FFFF);
        step_gap(1'b1, 10, 3'b000);
        chk("t2_wrap", position, 64'h8000_0000_0000_0000);
        chk("t2_no_setup_err", 64'(setup_err), 64'd0);

        // Overrun: interval 3 with MIN_PERIOD 4
        do_clear();
        step_gap(1'b1, 3, 3'b000);
        step_gap(1'b1, 10, 3'b000);
        chk("t3_overrun_set", 64'(overrun), 64'd1);
        chk("t3_pos_advanced", position, 64'd2);
        pulse_err_clr();
        chk("t3_overrun_clr", 64'(overrun), 64'd0);
        step_gap(1'b1, 3, 3'b000);
        step_gap(1'b1, 10, 3'b001);
        chk("t3_clr_vs_set", 64'(overrun), 64'd1);

        // Dir setup: change 1 cycle before step is an error, 2 cycles is legal
        do_clear();
        tick(4);
        dir_in = 1'b0;
        tick(1);
        step_gap(1'b0, 10, 3'b000);
        chk("t4_setup_err", 64'(setup_err), 64'd1);
        chk("t4_dir_out", 64'(dir_out), 64'd0);
        pulse_err_clr();
        chk("t4_setup_clr", 64'(setup_err), 64'd0);
        dir_in = 1'b1;
        tick(2);
        step_gap(1'b1, 10, 3'b000);
        chk("t4_setup_ok", 64'(setup_err), 64'd0);
        chk("t4_dir_out_pos", 64'(dir_out), 64'd1);

        // Stall: 8-bit timer saturates after 255 idle cycles
        do_clear();
        tick(4);
        repeat (3) step_gap(1'b1, 20, 3'b000);
        tick(300);
        chk("t5_stalled", 64'(stalled), 64'd1);
        chk("t5_stall_invalid", 64'(period_valid), 64'd0);
        step_gap(1'b1, 15, 3'b000);
        chk("t5_armed_stalled", 64'(stalled), 64'd0);
        chk("t5_armed_invalid", 64'(period_valid), 64'd0);
        step_gap(1'b1, 15, 3'b000);
        chk("t5_period15", 64'(period), 64'd15);
        chk("t5_valid", 64'(period_valid), 64'd1);

        // Capture coinciding with a step, then clear coinciding with a step
        do_clear();
        do_load(64'd8);
        step_gap(1'b1, 10, 3'b000);
        step_gap(1'b1, 10, 3'b010);
        chk("t6_cap_pos", cap_pos, 64'd10);
        chk("t6_cap_period", 64'(cap_period), 64'd10);
        step_gap(1'b1, 10, 3'b100);
        chk("t6_clear_pos", position, 64'd0);
        chk("t6_clear_period", 64'(period), 64'd0);
        chk("t6_clear_valid", 64'(period_valid), 64'd0);
        chk("t6_cap_pos_held", cap_pos, 64'd10);
        chk("t6_cap_per_held", 64'(cap_period), 64'd10);
        step_gap(1'b1, 10, 3'b000);
        chk("t6_idle_to_armed", 64'(period_valid), 64'd0);
        chk("t6_pos_after", position, 64'd1);

        // Asynchronous reset in the middle of activity
        step_gap(1'b1, 3, 3'b000);
        step_gap(1'b1, 10, 3'b000);
        chk("t7_pre_overrun", 64'(overrun), 64'd1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t7_position", position, 64'd0);
        chk("t7_period", 64'(period), 64'd0);
        chk("t7_valid_stall", 64'({period_valid, stalled}), 64'd0);
        chk("t7_dir_seen", 64'({dir_out, step_seen}), 64'd0);
        chk("t7_cap_pos", cap_pos, 64'd0);
        chk("t7_cap_period", 64'(cap_period), 64'd0);
        chk("t7_flags", 64'({overrun, setup_err}), 64'd0);
        tick(2);
        reset_n = 1'b1;
        tick(5);
        chk("q_drain", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
